// File: rtl/mmio_bus_initiator_if.sv
// Command, response and peripheral-bus signals of the MMIO bus initiator.
// The master modport is the initiator's view; slave is the user/peripheral view.
interface mmio_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wready;
  logic        wvalid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rready;
  logic        rvalid;
  logic [31:0] raddr;
  logic        rresp;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           wvalid, rvalid, rresp, rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           wready, waddr, wdata, wstrb, rready, raddr, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           wvalid, rvalid, rresp, rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           wready, waddr, wdata, wstrb, rready, raddr, busy
  );
endinterface

// File: rtl/mmio_bus_initiator.sv
// Queues local read/write commands and issues them one at a time on the
// wready/wvalid + rready/rvalid peripheral bus, returning in-order responses.
module mmio_bus_initiator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetb,
  mmio_bus_initiator_if.master  bus
);

  localparam int unsigned     PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned     CMD_W       = 69;
  localparam logic [15:0]     TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [PTR_W:0]  PTR_ONE     = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state;
  state_e           state_nxt;

  logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic             head_write;
  logic [31:0]      head_addr;
  logic [31:0]      head_wdata;
  logic [3:0]       head_wstrb;
  logic             head_misaligned;

  logic             cmd_write_q;
  logic [31:0]      cmd_addr_q;
  logic [31:0]      cmd_wdata_q;
  logic [3:0]       cmd_wstrb_q;
  logic             rsp_write_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;
  logic [15:0]      wait_cnt;

  logic             ack;
  logic             expire;
  logic             wready_d;
  logic             rready_d;
  logic             rsp_valid_d;

  // Command FIFO: extra pointer bit distinguishes full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;

  assign head            = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_write      = head[68];
  assign head_addr       = head[67:36];
  assign head_wdata      = head[35:4];
  assign head_wstrb      = head[3:0];
  assign head_misaligned = (head_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb};
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // An acknowledge in the final wait cycle takes priority over the abort
  assign expire = (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    ack         = 1'b0;
    wready_d    = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_misaligned) state_nxt = RESP;
          else if (head_write) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      WRITE: begin
        wready_d = 1'b1;
        ack      = bus.wvalid;
        if (ack || expire) state_nxt = RESP;
      end
      READ: begin
        rready_d = 1'b1;
        ack      = bus.rvalid;
        if (ack || expire) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wstrb_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt    <= '0;
    end else if (pop) begin
      cmd_write_q <= head_write;
      cmd_addr_q  <= head_addr;
      cmd_wdata_q <= head_wdata;
      cmd_wstrb_q <= head_wstrb;
      rsp_write_q <= head_write;
      rsp_err_q   <= head_misaligned;
      rsp_rdata_q <= '0;
      wait_cnt    <= '0;
    end else if (state == WRITE || state == READ) begin
      if (ack) begin
        if (state == READ) begin
          rsp_rdata_q <= bus.rdata;
          rsp_err_q   <= bus.rresp;
        end else begin
          rsp_err_q   <= 1'b0;
        end
      end else if (expire) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end else begin
        wait_cnt    <= wait_cnt + 16'd1;
      end
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.busy      = !fifo_empty || (state != IDLE);
  assign bus.wready    = wready_d;
  assign bus.rready    = rready_d;
  assign bus.waddr     = cmd_addr_q;
  assign bus.wdata     = cmd_wdata_q;
  assign bus.wstrb     = cmd_wstrb_q;
  assign bus.raddr     = cmd_addr_q;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  logic unused_cmd_write;
  assign unused_cmd_write = cmd_write_q;

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Randomized bench for mmio_bus_initiator: a transaction-level model of the
// command queue and per-command service timeline predicts every output each cycle.
module tb_mmio_bus_initiator;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk    = 1'b0;
  logic resetb = 1'b0;

  mmio_bus_initiator_if bif();

  mmio_bus_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        cur;
  bit          in_svc = 1'b0;
  bit          mis    = 1'b0;
  int          age    = 0;
  int          lat    = 0;
  logic [31:0] cur_rd = '0;
  bit          cur_rr = 1'b0;

  bit          dir_pend = 1'b0;
  int          dir_lat  = 0;
  logic [31:0] dir_rd   = '0;
  bit          dir_rr   = 1'b0;

  int rsp_mode = 1;
  bit stray    = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit done   = 1'b0;
  int req_cnt = 0, first_req = -1, first_rsp = -1, rsp_seen = 0, dut_acc = 0;
  logic        last_err = 1'b0, last_write = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int dlen();
    return (lat <= TMO) ? lat + 1 : TMO + 1;
  endfunction

  function automatic bit req_active();
    return in_svc && !mis && (age <= dlen());
  endfunction

  function automatic bit rsp_exp();
    return in_svc && (mis || age > dlen());
  endfunction

  task automatic check_cycle();
    bit          ra, re, e_err;
    logic [31:0] e_rd;
    ra    = req_active();
    re    = rsp_exp();
    e_err = mis || (lat > TMO) || (!cur.wr && cur_rr);
    e_rd  = (mis || (lat > TMO) || cur.wr) ? 32'h0 : cur_rd;
    chk("cmd_ready", bif.cmd_ready, 32'(q.size() < DEPTH));
    chk("busy",      bif.busy,      32'((q.size() > 0) || in_svc));
    chk("wready",    bif.wready,    32'(ra && cur.wr));
    chk("rready",    bif.rready,    32'(ra && !cur.wr));
    chk("rsp_valid", bif.rsp_valid, 32'(re));
    if (ra && cur.wr) begin
      chk("waddr", bif.waddr, cur.a);
      chk("wdata", bif.wdata, cur.wd);
      chk("wstrb", bif.wstrb, 32'(cur.st));
    end
    if (ra && !cur.wr) chk("raddr", bif.raddr, cur.a);
    if (re) begin
      chk("rsp_write", bif.rsp_write, 32'(cur.wr));
      chk("rsp_err",   bif.rsp_err,   32'(e_err));
      chk("rsp_rdata", bif.rsp_rdata, e_rd);
    end
    if (bif.wready || bif.rready) begin
      req_cnt++;
      if (first_req < 0) first_req = cyc + 1;
    end
    if (bif.rsp_valid) begin
      rsp_seen++;
      if (first_rsp < 0) first_rsp = cyc + 1;
      last_err   = bif.rsp_err;
      last_write = bif.rsp_write;
      last_rdata = bif.rsp_rdata;
    end
    if (bif.cmd_valid && bif.cmd_ready) dut_acc++;
  endtask

  task automatic model_edge();
    bit do_push, do_pop, do_cons;
    cyc++;
    if (!resetb) begin
      q.delete();
      in_svc = 1'b0;
      return;
    end
    do_cons = in_svc && rsp_exp() && bif.rsp_ready;
    do_pop  = !in_svc && (q.size() > 0);
    do_push = bif.cmd_valid && (q.size() < DEPTH);
    if (do_cons) begin
      in_svc = 1'b0;
      done   = 1'b1;
    end else if (in_svc) begin
      age++;
    end
    if (do_pop) begin
      cur    = q.pop_front();
      in_svc = 1'b1;
      age    = 1;
      mis    = (cur.a[1:0] != 2'b00);
      if (dir_pend) begin
        lat = dir_lat; cur_rd = dir_rd; cur_rr = dir_rr; dir_pend = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) lat = $urandom_range(TMO - 1, TMO + 2);
        else                           lat = $urandom_range(0, 4);
        cur_rd = $urandom;
        cur_rr = ($urandom_range(0, 3) == 0);
      end
    end
    if (do_push) q.push_back('{bif.cmd_write, bif.cmd_addr, bif.cmd_wdata, bif.cmd_wstrb});
  endtask

  task automatic drive_slave();
    bit ra, ack;
    ra  = req_active();
    ack = ra && (lat <= TMO) && (age == lat + 1);
    bif.rdata = $urandom;
    bif.rresp = (($urandom & 1) == 1);
    if (ra) begin
      bif.wvalid = cur.wr  ? ack : (($urandom & 1) == 1);
      bif.rvalid = !cur.wr ? ack : (($urandom & 1) == 1);
      if (ack && !cur.wr) begin
        bif.rdata = cur_rd;
        bif.rresp = cur_rr;
      end
    end else begin
      bif.wvalid = stray || ($urandom_range(0, 2) == 0);
      bif.rvalid = stray || ($urandom_range(0, 2) == 0);
    end
    case (rsp_mode)
      0:       bif.rsp_ready = 1'b0;
      1:       bif.rsp_ready = 1'b1;
      default: bif.rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
    drive_slave();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    bif.cmd_valid = 1'b0;
    while ((q.size() > 0 || in_svc) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", nm, n);
    end
  endtask

  task automatic directed(input string nm, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input int l,
                          input logic [31:0] rd, input bit rr, input int exp_req,
                          input int exp_off, input bit exp_err, input logic [31:0] exp_rd);
    int n, push_edge;
    rsp_mode = 1;
    wait_idle(nm);
    dir_pend = 1'b1; dir_lat = l; dir_rd = rd; dir_rr = rr;
    req_cnt = 0; first_req = -1; first_rsp = -1; rsp_seen = 0; done = 1'b0;
    bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_addr = a;
    bif.cmd_wdata = wd;   bif.cmd_wstrb = st;
    cycle();
    push_edge = cyc;
    bif.cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_done: no response after %0d cycles", nm, n);
    end
    chk({nm, "_req_cycles"}, req_cnt, exp_req);
    if (exp_req > 0) chk({nm, "_req_at"}, first_req - push_edge, 2);
    chk({nm, "_rsp_at"}, first_rsp - push_edge, exp_off);
    chk({nm, "_rsp_count"}, rsp_seen, 1);
    chk({nm, "_err"}, last_err, 32'(exp_err));
    chk({nm, "_write"}, last_write, 32'(wr));
    chk({nm, "_rdata"}, last_rdata, exp_rd);
  endtask

  initial begin
    int n, base;
    bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0;
    bif.cmd_wdata = '0;   bif.cmd_wstrb = '0;   bif.rsp_ready = 1'b0;
    bif.wvalid = 1'b0;    bif.rvalid = 1'b0;    bif.rresp = 1'b0; bif.rdata = '0;

    #12;
    chk("rst_cmd_ready", bif.cmd_ready, 1);
    chk("rst_busy",      bif.busy,      0);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_write", bif.rsp_write, 0);
    chk("rst_rsp_err",   bif.rsp_err,   0);
    chk("rst_rsp_rdata", bif.rsp_rdata, 0);
    chk("rst_wready",    bif.wready,    0);
    chk("rst_rready",    bif.rready,    0);
    chk("rst_waddr",     bif.waddr,     0);
    chk("rst_wdata",     bif.wdata,     0);
    chk("rst_wstrb",     bif.wstrb,     0);
    chk("rst_raddr",     bif.raddr,     0);
    @(posedge clk);
    #1 resetb = 1'b1;

    directed("wr_fast", 1'b1, 32'h0200_4000, 32'h0000_1234, 4'hF, 0, 32'h0, 1'b0,
             1, 3, 1'b0, 32'h0);
    directed("rd_wait3", 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0,
             4, 6, 1'b0, 32'hDEAD_BEEF);
    directed("rd_misal", 1'b0, 32'h0000_0006, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0,
             0, 2, 1'b1, 32'h0);
    directed("rd_rresp", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b1,
             2, 4, 1'b1, 32'hCAFE_F00D);
    directed("wr_strb0", 1'b1, 32'h0200_0004, 32'h5555_AAAA, 4'h0, 2, 32'h0, 1'b0,
             3, 5, 1'b0, 32'h0);
    stray = 1'b1;
    directed("rd_tmo", 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 20, 32'h0, 1'b0,
             TMO + 1, TMO + 3, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle();
    chk("tmo_no_second_rsp", rsp_seen, 1);
    stray = 1'b0;

    // Fill the FIFO while the first response is held back
    wait_idle("full");
    rsp_mode = 0;
    base = dut_acc;
    for (int i = 0; i < 5; i++) begin
      bif.cmd_valid = 1'b1; bif.cmd_write = (i % 2 == 0);
      bif.cmd_addr = 32'h1000_0000 + 32'(i * 16); bif.cmd_wdata = $urandom;
      bif.cmd_wstrb = 4'hF;
      cycle();
    end
    chk("full_accepted", dut_acc - base, 5);
    bif.cmd_addr = 32'h1000_0100;
    for (int i = 0; i < 20; i++) cycle();
    chk("full_hold", dut_acc - base, 5);
    chk("full_cmd_ready", bif.cmd_ready, 0);
    rsp_mode = 2;
    n = 0;
    while (dut_acc - base < 6 && n < 300) begin
      cycle();
      n++;
    end
    chk("full_sixth_accepted", dut_acc - base, 6);
    wait_idle("full_drain");

    // Reset while a read is outstanding with two commands queued
    rsp_mode = 1;
    wait_idle("rst");
    dir_pend = 1'b1; dir_lat = 50; dir_rd = '0; dir_rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0;
      bif.cmd_addr = 32'h2000_0000 + 32'(i * 4);
      cycle();
    end
    bif.cmd_valid = 1'b0;
    #2;
    chk("rst_pre_rready", bif.rready, 1);
    chk("rst_pre_busy",   bif.busy,   1);
    resetb = 1'b0;
    q.delete(); in_svc = 1'b0; dir_pend = 1'b0;
    #1;
    chk("rst_async_rready",    bif.rready,    0);
    chk("rst_async_busy",      bif.busy,      0);
    chk("rst_async_cmd_ready", bif.cmd_ready, 1);
    chk("rst_async_rsp_valid", bif.rsp_valid, 0);
    for (int i = 0; i < 3; i++) cycle();
    resetb = 1'b1;
    base = rsp_seen;
    for (int i = 0; i < 30; i++) cycle();
    chk("rst_no_rsp_after", rsp_seen - base, 0);

    // Randomized traffic
    rsp_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      bif.cmd_valid = ($urandom_range(0, 2) == 0);
      bif.cmd_write = (($urandom & 1) == 1);
      bif.cmd_addr  = a;
      bif.cmd_wdata = $urandom;
      bif.cmd_wstrb = 4'($urandom_range(0, 15));
      cycle();
    end
    wait_idle("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
